// File: rtl/bus_datapath_pkg.sv
// Shared types and constants for the register-transfer datapath.
// Holds bus width, memory FSM states and rd_wr encoding.
package bus_datapath_pkg;

  localparam int DP_WIDTH = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_handshake.sv
// Memory-access handshake: start edge detect, IDLE/REQ/WAIT/DONE FSM, timeout.
// In: mem_active, rd_wr, mar, mdr, mem_ack. Out: mem_* and rdata capture strobe.
module mem_handshake
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH   = DP_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_active,
  input  logic             rd_wr,
  input  logic [WIDTH-1:0] mar,
  input  logic [WIDTH-1:0] mdr,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic             capture
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t      state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            act_q;
  logic            rd_q;
  logic            err_q;
  logic            start;
  logic            timeout;

  // Only a fresh rising edge while idle starts an access.
  assign start = mem_active & ~act_q & (state == IDLE);

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    timeout = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = REQ;
      REQ: begin
        nxt     = WAIT;
        cnt_nxt = '0;
      end
      WAIT: begin
        if (mem_ack) begin
          nxt     = DONE;
          capture = rd_q;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          nxt     = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      act_q     <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      act_q <= mem_active;
      err_q <= timeout;
      if (start) begin
        mem_addr  <= mar;
        mem_wdata <= mdr;
        rd_q      <= (rd_wr == RW_READ);
      end
    end
  end

  assign mem_req  = (state == REQ) | (state == WAIT);
  assign mem_we   = mem_req & ~rd_q;
  assign mem_busy = (state != IDLE);
  assign mem_done = (state == DONE);
  assign mem_err  = err_q;

endmodule

// File: rtl/bus_datapath.sv
// Shared-bus datapath: PC, MAR, MDR, IR, SP, Y registers and bus mux.
// Transfer strobes pick the bus source, load strobes capture it; memory via mem_handshake.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int               WIDTH    = DP_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] SP_INIT  = '1,
  parameter int               TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             t_pc,
  input  logic             t_mar,
  input  logic             t_mdr,
  input  logic             t_ir,
  input  logic             t_sp,
  input  logic             l_y,
  input  logic             l_pc,
  input  logic             l_mar,
  input  logic             l_mdr,
  input  logic             l_ir,
  input  logic             l_sp,
  input  logic             mem_active,
  input  logic             rd_wr,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] bus,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err
);

  logic [WIDTH-1:0] pc_q, mar_q, mdr_q, ir_q, sp_q, y_q;
  logic [5:0]       sel;
  logic             multi;
  logic             ld_ok;
  logic             cap;
  logic             err_q;

  assign sel   = {y, t_pc, t_mar, t_mdr, t_ir, t_sp};
  assign multi = $countones(sel) > 1;
  assign ld_ok = ~multi;

  // Conflicting sources fall to default and read as zero.
  always_comb begin
    bus = '0;
    case (sel)
      6'b100000: bus = y_q;
      6'b010000: bus = pc_q;
      6'b001000: bus = mar_q;
      6'b000100: bus = mdr_q;
      6'b000010: bus = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
      6'b000001: bus = sp_q;
      default:   bus = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      sp_q  <= SP_INIT;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= multi;
      if (l_pc  & ld_ok) pc_q  <= bus;
      if (l_sp  & ld_ok) sp_q  <= bus;
      if (l_mar & ld_ok) mar_q <= bus;
      if (l_ir  & ld_ok) ir_q  <= bus;
      if (l_y   & ld_ok) y_q   <= bus;
      // Read data from memory takes priority over a bus load.
      if (cap)                mdr_q <= mem_rdata;
      else if (l_mdr & ld_ok) mdr_q <= bus;
    end
  end

  assign IR      = ir_q;
  assign bus_err = err_q;

  mem_handshake #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .mem_active (mem_active),
    .rd_wr      (rd_wr),
    .mar        (mar_q),
    .mdr        (mdr_q),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done),
    .mem_err    (mem_err),
    .capture    (cap)
  );

endmodule

// File: tb/tb_bus_datapath.sv
// Self-checking bench for bus_datapath: directed plan plus randomized transfers.
// Register model is an array indexed Y,PC,MAR,MDR,IR,SP updated from bus rules.
module tb_bus_datapath;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        y, t_pc, t_mar, t_mdr, t_ir, t_sp;
  logic        l_y, l_pc, l_mar, l_mdr, l_ir, l_sp;
  logic        mem_active, rd_wr;
  logic [15:0] IR, bus, mem_addr, mem_wdata, mem_rdata;
  logic        bus_err, mem_req, mem_we, mem_ack;
  logic        mem_busy, mem_done, mem_err;

  bus_datapath dut (
    .clk(clk), .rst(rst),
    .y(y), .t_pc(t_pc), .t_mar(t_mar), .t_mdr(t_mdr),
    .t_ir(t_ir), .t_sp(t_sp),
    .l_y(l_y), .l_pc(l_pc), .l_mar(l_mar), .l_mdr(l_mdr),
    .l_ir(l_ir), .l_sp(l_sp),
    .mem_active(mem_active), .rd_wr(rd_wr),
    .IR(IR), .bus(bus), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // 0 Y, 1 PC, 2 MAR, 3 MDR, 4 IR, 5 SP
  logic [15:0] r [6];
  logic [15:0] cur_bus;
  logic [5:0]  cur_ld;
  logic        cur_conf;
  logic        pe;
  logic        cap_pend;
  logic [15:0] cap_val;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sv(input int i);
    return (i == 4) ? {4'h0, r[4][11:0]} : r[i];
  endfunction

  task automatic reset_model();
    r[0] = 16'h0000; r[1] = 16'h0000; r[2] = 16'h0000;
    r[3] = 16'h0000; r[4] = 16'h0000; r[5] = 16'hFFFF;
    pe = 1'b0;
    cap_pend = 1'b0;
  endtask

  task automatic drive(input logic [5:0] src, input logic [5:0] ld);
    {t_sp, t_ir, t_mdr, t_mar, t_pc, y} = src;
    {l_sp, l_ir, l_mdr, l_mar, l_pc, l_y} = ld;
    cur_ld = ld;
    cur_conf = $countones(src) > 1;
    cur_bus = 16'h0000;
    if ($countones(src) == 1)
      for (int i = 0; i < 6; i++)
        if (src[i]) cur_bus = sv(i);
  endtask

  task automatic mid();
    @(negedge clk);
    chk("bus", bus, cur_bus);
    chk("bus_err", {15'h0, bus_err}, {15'h0, pe});
    chk("IR", IR, r[4]);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    if (!cur_conf)
      for (int i = 0; i < 6; i++)
        if (cur_ld[i]) r[i] = cur_bus;
    if (cap_pend) r[3] = cap_val;
    cap_pend = 1'b0;
    pe = cur_conf;
  endtask

  task automatic cyc(input logic [5:0] src, input logic [5:0] ld);
    drive(src, ld);
    mid();
    fin();
  endtask

  task automatic peek(input int i);
    cyc(6'(1 << i), 6'h00);
  endtask

  // ack_at >= TMO means the access is never acknowledged.
  task automatic mem_access(input logic rd, input logic [15:0] rdata,
                            input int ack_at, input bit hold);
    logic [15:0] a0, d0;
    a0 = r[2];
    d0 = r[3];
    drive(6'h00, 6'h00);
    mem_active = 1'b1; rd_wr = rd; mem_ack = 1'b0;
    mid();
    chk("start_busy", {15'h0, mem_busy}, 16'h0);
    fin();
    // REQ: disturb MAR, rd_wr and present an early ack.
    drive(6'b000010, 6'b000100);
    mem_active = hold; rd_wr = ~rd;
    mem_ack = 1'b1; mem_rdata = ~rdata;
    mid();
    chk("req", {15'h0, mem_req}, 16'h1);
    chk("busy", {15'h0, mem_busy}, 16'h1);
    chk("addr", mem_addr, a0);
    chk("we", {15'h0, mem_we}, {15'h0, ~rd});
    if (!rd) chk("wdata", mem_wdata, d0);
    fin();
    for (int w = 0; w < TMO; w++) begin
      mem_ack = (w == ack_at);
      mem_rdata = rdata;
      if (w == ack_at && rd) drive(6'b000010, 6'b001000);
      else drive(6'h00, 6'h00);
      mid();
      chk("wait_req", {15'h0, mem_req}, 16'h1);
      chk("wait_done", {15'h0, mem_done}, 16'h0);
      chk("wait_addr", mem_addr, a0);
      if (w == ack_at) begin
        if (rd) begin
          cap_pend = 1'b1;
          cap_val = rdata;
        end
        fin();
        break;
      end
      fin();
    end
    mem_ack = 1'b0;
    drive(6'h00, 6'h00);
    mid();
    if (ack_at < TMO) begin
      chk("done", {15'h0, mem_done}, 16'h1);
      chk("done_req", {15'h0, mem_req}, 16'h0);
      chk("done_err", {15'h0, mem_err}, 16'h0);
      fin();
      mid();
      chk("done_pulse", {15'h0, mem_done}, 16'h0);
      chk("idle_busy", {15'h0, mem_busy}, 16'h0);
      fin();
    end else begin
      chk("err", {15'h0, mem_err}, 16'h1);
      chk("err_req", {15'h0, mem_req}, 16'h0);
      chk("err_busy", {15'h0, mem_busy}, 16'h0);
      chk("err_done", {15'h0, mem_done}, 16'h0);
      fin();
      mid();
      chk("err_pulse", {15'h0, mem_err}, 16'h0);
      fin();
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        drive(6'h00, 6'h00);
        mid();
        chk("hold_busy", {15'h0, mem_busy}, 16'h0);
        chk("hold_req", {15'h0, mem_req}, 16'h0);
        fin();
      end
    end
    mem_active = 1'b0;
  endtask

  // Read a value into MDR, then copy it into MAR.
  task automatic set_mar(input logic [15:0] v);
    mem_access(1'b1, v, 0, 1'b0);
    cyc(6'b001000, 6'b000100);
  endtask

  initial begin
    rst = 1'b1;
    mem_active = 1'b0; rd_wr = 1'b1; mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    drive(6'h00, 6'h00);
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(6'h00, 6'h00);
    mid();
    chk("rst_req", {15'h0, mem_req}, 16'h0);
    chk("rst_busy", {15'h0, mem_busy}, 16'h0);
    fin();
    peek(1);
    peek(5);

    cyc(6'b000010, 6'b000100);
    cyc(6'b000100, 6'b000001);
    peek(2);
    peek(0);

    mem_access(1'b1, 16'h1234, 0, 1'b0);
    cyc(6'b001000, 6'b000010);
    cyc(6'b000010, 6'b000100);
    peek(2);

    set_mar(16'h0010);
    mem_access(1'b1, 16'hF020, 0, 1'b0);
    cyc(6'b001000, 6'b010000);
    peek(3);

    set_mar(16'h0020);
    mem_access(1'b1, 16'hABCD, 1, 1'b0);
    mem_access(1'b0, 16'h5555, 2, 1'b0);
    peek(3);

    cyc(6'b100010, 6'b010000);
    cyc(6'h00, 6'h00);
    cyc(6'h00, 6'h00);

    cyc(6'b000010, 6'b000010);
    peek(1);

    mem_access(1'b1, 16'h7777, TMO, 1'b0);
    peek(3);

    mem_access(1'b1, 16'h4242, 0, 1'b1);
    peek(3);

    drive(6'h00, 6'h00);
    mem_active = 1'b1; rd_wr = 1'b1;
    fin();
    mem_active = 1'b0;
    fin();
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_req", {15'h0, mem_req}, 16'h0);
    chk("rst_wait_busy", {15'h0, mem_busy}, 16'h0);
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_done", {15'h0, mem_done}, 16'h0);
    chk("rst_no_err", {15'h0, mem_err}, 16'h0);
    mem_ack = 1'b0;
    rst = 1'b0;
    reset_model();
    peek(1);
    peek(5);
    peek(3);

    for (int it = 0; it < 250; it++) begin
      int k;
      logic [5:0] src;
      k = $urandom_range(0, 9);
      src = 6'h00;
      if (k == 0) begin
        mem_access(1'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b0);
      end else begin
        if (k == 1) begin
          int a, b;
          a = $urandom_range(0, 5);
          b = (a + $urandom_range(1, 5)) % 6;
          src[a] = 1'b1;
          src[b] = 1'b1;
        end else if (k != 2) begin
          src[$urandom_range(0, 5)] = 1'b1;
        end
        cyc(src, 6'($urandom));
      end
    end
    for (int i = 0; i < 6; i++) peek(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Register-transfer datapath directly downstream of the multi-cycle `controller`.
- Consumes its load (l_*) and transfer (t_*, y) strobes plus mem_active/rd_wr.
- Owns the single shared 16-bit internal bus and the PC, MAR, MDR, IR, SP and Y registers.
- Runs the memory-access handshake and feeds IR back to the controller.

Parameters:
- WIDTH, 16, bus and register width.
- RESET_PC, 16'h0000, PC value after reset.
- SP_INIT, 16'hFFFF, SP value after reset.
- TIMEOUT, 15, maximum cycles in WAIT before the access is aborted.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- y  in  1  Y register drives the bus.
- t_pc, t_mar, t_mdr, t_sp  in  1 each  named register drives the bus.
- t_ir  in  1  IR[11:0], zero-extended to WIDTH, drives the bus (address field).
- l_y, l_pc, l_mar, l_mdr, l_ir, l_sp  in  1 each  named register captures the bus.
- mem_active  in  1  controller memory request.
- rd_wr  in  1  1 = read, 0 = write.
- IR  out  WIDTH  instruction register, returned to the controller.
- bus  out  WIDTH  current internal bus value (observability).
- bus_err  out  1  registered one-cycle pulse: transfer-source conflict.
- mem_req  out  1  external memory request.
- mem_we  out  1  external write enable.
- mem_addr  out  WIDTH  external address.
- mem_wdata  out  WIDTH  external write data.
- mem_rdata  in  WIDTH  external read data.
- mem_ack  in  1  external memory acknowledge.
- mem_busy  out  1  a transaction is in progress (state not IDLE).
- mem_done  out  1  one-cycle pulse: access completed.
- mem_err  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (async, immediate):
  - PC = RESET_PC, SP = SP_INIT; MAR, MDR, IR, Y = 0.
  - FSM = IDLE; timeout counter = 0; mem_active edge register = 0.
  - All pulse outputs and mem_req/mem_we = 0.
  - Reset mid-transaction aborts it silently: no mem_done, no mem_err.
- Bus (combinational):
  - Exactly one of {y, t_pc, t_mar, t_mdr, t_ir, t_sp} high: bus = that source.
  - None high: bus = 0.
  - Two or more high: bus = 0, all l_* loads suppressed that cycle, bus_err pulses the next cycle.
- Loads: every asserted l_* register captures bus at the rising edge.
  - Several loads in one cycle are legal (fan-out).
  - Load and transfer of the same register in one cycle: register reloads its own value.
- Memory FSM, states IDLE, REQ, WAIT, DONE:
  - IDLE: a rising edge of mem_active (high now, low last cycle) latches MAR into mem_addr, MDR into mem_wdata and ~rd_wr into mem_we, then goes to REQ. A level held high does not retrigger.
  - REQ: mem_req = 1 for one cycle; go to WAIT with counter = 0.
  - WAIT: mem_req stays 1.
    - mem_ack high: on a read, MDR <= mem_rdata; go to DONE.
    - Otherwise counter increments; counter == TIMEOUT-1 without ack: mem_err pulses, mem_req drops, return to IDLE, MDR unchanged.
  - DONE: mem_req = 0, mem_done = 1 for exactly one cycle; return to IDLE.
  - mem_ack seen outside WAIT is ignored.
  - Transaction latency: start edge to mem_done is 3 cycles with ack on the first WAIT cycle.
- Changes on mem_active, rd_wr or MAR while mem_busy is high are ignored; the access uses the values latched at start.
- The read capture into MDR and l_mdr in the same cycle: memory capture wins, l_mdr is dropped.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3);
  - WIDTH;
  - the rd_wr read/write encoding constants, so the controller and datapath agree.
- One sub-module: mem_handshake, containing the FSM, timeout counter and edge detect. Its inputs are mem_active, rd_wr, MAR, MDR and mem_ack; its outputs are the mem_* signals plus an rdata-capture strobe.
- The register file and bus mux stay in bus_datapath.

Test Plan:
- Reset release -> PC = 0000, SP = FFFF, IR = 0000, bus = 0000, mem_req = 0.
- t_pc = 1, l_mar = 1 for one cycle, then t_mar = 1, l_y = 1 -> MAR = 0000, Y = 0000; then with PC loaded to 1234, t_pc and l_mar give MAR = 1234.
- MAR = 0010, rising mem_active with rd_wr = 1, mem_ack in the first WAIT cycle with mem_rdata = F020 -> mem_addr = 0010, mem_we = 0, MDR = F020, mem_done high 3 cycles after the edge; then t_mdr and l_ir give IR = F020.
- Write access with MDR = ABCD, MAR = 0020, rd_wr = 0 -> mem_we = 1, mem_wdata = ABCD, mem_addr = 0020; MDR is unchanged after ack.
- t_pc and t_sp both high with l_ir high -> bus = 0000, IR unchanged, bus_err pulses one cycle.
- Read with mem_ack never asserted -> mem_err pulses after 15 WAIT cycles, FSM back in IDLE, MDR unchanged.
- mem_active held high across mem_done -> no second access.
- rst asserted during WAIT -> mem_req drops immediately, no mem_done.
